// File: rtl/msix_pkg.sv
// Shared types and encodings for the MSI-X interrupt generator.
package msix_pkg;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
      logic        mask;
   } msix_entry_t;

   localparam logic [1:0] MSIX_F_ADDR_LO = 2'd0;
   localparam logic [1:0] MSIX_F_ADDR_HI = 2'd1;
   localparam logic [1:0] MSIX_F_DATA    = 2'd2;
   localparam logic [1:0] MSIX_F_CTRL    = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } msix_state_t;

   // Table entries come out of reset with zero address/data and masked.
   function automatic msix_entry_t msix_entry_rst();
      msix_entry_t e;
      e.addr = 64'd0;
      e.data = 32'd0;
      e.mask = 1'b1;
      return e;
   endfunction

endpackage

// File: rtl/msix_arb.sv
// Vector arbiter: request vector -> one-hot grant, index and any-flag.
// MSIX_RR_ARB_EN selects round-robin; otherwise lowest index wins.
module msix_arb
   import msix_pkg::*;
#(
   parameter int unsigned NUM_VEC = 4,
   parameter int unsigned VEC_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_VEC-1:0] req,
   input  logic               upd,
   input  logic [VEC_W-1:0]   upd_idx,
   output logic [NUM_VEC-1:0] grant_c,
   output logic [VEC_W-1:0]   idx_c,
   output logic               any_c
);

   logic [NUM_VEC-1:0] sel_req;

`ifdef MSIX_RR_ARB_EN
   logic [VEC_W-1:0]   ptr_q;
   logic [NUM_VEC-1:0] hi_mask;
   logic [NUM_VEC-1:0] req_hi;

   // Pointer holds the index where the next search starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (upd) begin
         if (32'(upd_idx) == NUM_VEC - 1) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= upd_idx + VEC_W'(1);
         end
      end
   end

   // Requests at or above the pointer take precedence; wrap to the rest otherwise.
   always_comb begin
      hi_mask = '0;
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
         hi_mask[i] = (32'(ptr_q) <= i);
      end
      req_hi  = req & hi_mask;
      sel_req = (|req_hi) ? req_hi : req;
   end
`else
   logic unused_arb;

   assign unused_arb = ^{clk, rst, upd, upd_idx};
   assign sel_req    = req;
`endif

   always_comb begin
      logic found;
      found   = 1'b0;
      grant_c = '0;
      idx_c   = '0;
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
         if (sel_req[i] && !found) begin
            found      = 1'b1;
            grant_c[i] = 1'b1;
            idx_c      = VEC_W'(i);
         end
      end
      any_c = found;
   end

endmodule

// File: rtl/msix_intr_gen.sv
// MSI-X interrupt generator: vector table, pending bits and DW write issue.
// Define MSIX_RR_ARB_EN for round-robin vector arbitration.
module msix_intr_gen
   import msix_pkg::*;
#(
   parameter int unsigned NUM_VEC = 4,
   parameter int unsigned VEC_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_VEC-1:0] intr_req,
   input  logic               msix_enable,
   input  logic               func_mask,
   input  logic               cfg_we,
   input  logic [VEC_W-1:0]   cfg_vec,
   input  logic [1:0]         cfg_field,
   input  logic [31:0]        cfg_wdata,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [63:0]        wr_addr,
   output logic [31:0]        wr_data,
   output logic [VEC_W-1:0]   wr_vec,
   output logic [NUM_VEC-1:0] pending,
   output logic               busy
);

   msix_entry_t        tbl [NUM_VEC];
   msix_state_t        state_q;
   msix_state_t        state_d;
   logic               load;
   logic               hs;
   logic [NUM_VEC-1:0] mask_vec;
   logic [NUM_VEC-1:0] elig;
   logic [NUM_VEC-1:0] hs_clr;
   logic [NUM_VEC-1:0] arb_grant;
   logic [VEC_W-1:0]   arb_idx;
   logic               arb_any;
   logic [63:0]        sel_addr;
   logic [31:0]        sel_data;

   assign hs = wr_valid & wr_ready;

   // Out-of-range cfg_vec matches no entry, so the write is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_VEC; i++) begin
            tbl[i] <= msix_entry_rst();
         end
      end else if (cfg_we) begin
         for (int unsigned i = 0; i < NUM_VEC; i++) begin
            if (cfg_vec == VEC_W'(i)) begin
               case (cfg_field)
                  MSIX_F_ADDR_LO: tbl[i].addr[31:0]  <= cfg_wdata;
                  MSIX_F_ADDR_HI: tbl[i].addr[63:32] <= cfg_wdata;
                  MSIX_F_DATA:    tbl[i].data        <= cfg_wdata;
                  MSIX_F_CTRL:    tbl[i].mask        <= cfg_wdata[0];
                  default:        ;
               endcase
            end
         end
      end
   end

   always_comb begin
      mask_vec = '0;
      hs_clr   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
         mask_vec[i] = tbl[i].mask;
         hs_clr[i]   = hs && (wr_vec == VEC_W'(i));
         if (arb_grant[i]) begin
            sel_addr = sel_addr | tbl[i].addr;
            sel_data = sel_data | tbl[i].data;
         end
      end
   end

   assign elig = pending & ~mask_vec & {NUM_VEC{msix_enable & ~func_mask}};

   msix_arb #(
      .NUM_VEC (NUM_VEC),
      .VEC_W   (VEC_W)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (elig),
      .upd     (hs),
      .upd_idx (wr_vec),
      .grant_c (arb_grant),
      .idx_c   (arb_idx),
      .any_c   (arb_any)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               state_d = SEND;
               load    = 1'b1;
            end
         end
         SEND: begin
            if (wr_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request fields are captured once and held until the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_valid <= 1'b0;
         busy     <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_vec   <= '0;
         pending  <= '0;
      end else begin
         state_q  <= state_d;
         wr_valid <= (state_d == SEND);
         busy     <= (state_d == SEND);
         if (load) begin
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_vec  <= arb_idx;
         end
         // A new event on the vector being cleared keeps it pending.
         pending <= (pending & ~hs_clr) | intr_req;
      end
   end

endmodule

// File: tb/tb_msix_intr_gen.sv
// Directed bench for msix_intr_gen with a write-request scoreboard.
module tb_msix_intr_gen;
   import msix_pkg::*;

   localparam int unsigned NUM_VEC = 4;
   localparam int unsigned VEC_W   = 2;

   typedef struct {
      logic [63:0]      addr;
      logic [31:0]      data;
      logic [VEC_W-1:0] vec;
   } exp_t;

   logic               clk;
   logic               rst;
   logic [NUM_VEC-1:0] intr_req;
   logic               msix_enable;
   logic               func_mask;
   logic               cfg_we;
   logic [VEC_W-1:0]   cfg_vec;
   logic [1:0]         cfg_field;
   logic [31:0]        cfg_wdata;
   logic               wr_valid;
   logic               wr_ready;
   logic [63:0]        wr_addr;
   logic [31:0]        wr_data;
   logic [VEC_W-1:0]   wr_vec;
   logic [NUM_VEC-1:0] pending;
   logic               busy;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   msix_intr_gen #(
      .NUM_VEC (NUM_VEC),
      .VEC_W   (VEC_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .intr_req    (intr_req),
      .msix_enable (msix_enable),
      .func_mask   (func_mask),
      .cfg_we      (cfg_we),
      .cfg_vec     (cfg_vec),
      .cfg_field   (cfg_field),
      .cfg_wdata   (cfg_wdata),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_vec      (wr_vec),
      .pending     (pending),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [31:0] d, input int v);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.vec  = VEC_W'(v);
      exp_q.push_back(e);
   endtask

   task automatic cfg_wr(input int v, input logic [1:0] f, input logic [31:0] d);
      cfg_we    = 1'b1;
      cfg_vec   = VEC_W'(v);
      cfg_field = f;
      cfg_wdata = d;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   task automatic prog(input int v, input logic [63:0] a, input logic [31:0] d, input logic m);
      cfg_wr(v, MSIX_F_ADDR_LO, a[31:0]);
      cfg_wr(v, MSIX_F_ADDR_HI, a[63:32]);
      cfg_wr(v, MSIX_F_DATA, d);
      cfg_wr(v, MSIX_F_CTRL, {31'd0, m});
   endtask

   // Scoreboard: a handshake will occur at the coming rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_vec", 64'(wr_vec), 64'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("sb_wr_addr", wr_addr, e.addr);
            check("sb_wr_data", 64'(wr_data), 64'(e.data));
            check("sb_wr_vec", 64'(wr_vec), 64'(e.vec));
         end
      end
   end

   initial begin
      rst         = 1'b1;
      intr_req    = '0;
      msix_enable = 1'b0;
      func_mask   = 1'b0;
      cfg_we      = 1'b0;
      cfg_vec     = '0;
      cfg_field   = '0;
      cfg_wdata   = '0;
      wr_ready    = 1'b0;
      tick(3);
      check("rst_wr_valid", 64'(wr_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_wr_addr", wr_addr, 64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
      check("rst_wr_vec", 64'(wr_vec), 64'd0);
      rst = 1'b0;

      // Basic write from vector 0 with minimum latency.
      prog(0, 64'h0000_0000_0000_0001, 32'h1234_5678, 1'b0);
      msix_enable = 1'b1;
      wr_ready    = 1'b1;
      push_exp(64'h1, 32'h1234_5678, 0);
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      check("t1_pending_set", 64'(pending), 64'h1);
      check("t1_no_valid_yet", 64'(wr_valid), 64'd0);
      tick(1);
      check("t1_valid_n2", 64'(wr_valid), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_wr_addr", wr_addr, 64'h1);
      check("t1_wr_data", 64'(wr_data), 64'h1234_5678);
      tick(1);
      check("t1_valid_drop", 64'(wr_valid), 64'd0);
      check("t1_pending_clr", 64'(pending), 64'd0);

      // Masked vector latches, unmask yields exactly one write.
      prog(1, 64'h0000_000A_0000_0100, 32'hAAAA_0001, 1'b1);
      intr_req = 4'b0010;
      tick(1);
      intr_req = '0;
      tick(5);
      check("t2_masked_pending", 64'(pending), 64'h2);
      check("t2_masked_no_valid", 64'(wr_valid), 64'd0);
      push_exp(64'h0000_000A_0000_0100, 32'hAAAA_0001, 1);
      cfg_wr(1, MSIX_F_CTRL, 32'hFFFF_FFFE);
      tick(5);
      check("t2_pending_clr", 64'(pending), 64'd0);
      check("t2_one_write", 64'(exp_q.size()), 64'd0);

      // Function mask: three events coalesce into one write.
      prog(2, 64'h0000_0000_0000_0200, 32'hBBBB_0002, 1'b0);
      func_mask = 1'b1;
      for (int i = 0; i < 3; i++) begin
         intr_req = 4'b0100;
         tick(1);
         intr_req = '0;
         tick(2);
      end
      check("t3_fmask_pending", 64'(pending), 64'h4);
      check("t3_fmask_no_valid", 64'(wr_valid), 64'd0);
      push_exp(64'h200, 32'hBBBB_0002, 2);
      func_mask = 1'b0;
      tick(6);
      check("t3_pending_clr", 64'(pending), 64'd0);
      check("t3_one_write", 64'(exp_q.size()), 64'd0);

      // Backpressure: in-flight request is frozen against table/enable changes.
      wr_ready = 1'b0;
      push_exp(64'h1, 32'h1234_5678, 0);
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      tick(1);
      check("t4_valid", 64'(wr_valid), 64'd1);
      cfg_wr(0, MSIX_F_ADDR_LO, 32'h0000_DEAD);
      cfg_wr(0, MSIX_F_DATA, 32'hCAFE_F00D);
      cfg_wr(0, MSIX_F_CTRL, 32'h1);
      msix_enable = 1'b0;
      func_mask   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         check("t4_hold_addr", wr_addr, 64'h1);
         check("t4_hold_data", 64'(wr_data), 64'h1234_5678);
         check("t4_hold_valid", 64'(wr_valid), 64'd1);
      end
      msix_enable = 1'b1;
      func_mask   = 1'b0;
      wr_ready    = 1'b1;
      tick(1);
      check("t4_valid_drop", 64'(wr_valid), 64'd0);
      check("t4_pending_clr", 64'(pending), 64'd0);
      cfg_wr(0, MSIX_F_CTRL, 32'h0);

      // Event coincident with handshake keeps vector pending: two writes.
      push_exp(64'h0000_DEAD, 32'hCAFE_F00D, 0);
      push_exp(64'h0000_DEAD, 32'hCAFE_F00D, 0);
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      tick(1);
      check("t5_valid", 64'(wr_valid), 64'd1);
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      check("t5_set_wins", 64'(pending), 64'h1);
      tick(5);
      check("t5_pending_clr", 64'(pending), 64'd0);
      check("t5_two_writes", 64'(exp_q.size()), 64'd0);

      // All vectors pending from reset: grant order 0,1,2,3.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int v = 0; v < 4; v++) begin
         prog(v, {32'h1, 32'(v) * 32'h100 + 32'h40}, 32'hD000_0000 + 32'(v), 1'b0);
      end
      for (int v = 0; v < 4; v++) begin
         push_exp({32'h1, 32'(v) * 32'h100 + 32'h40}, 32'hD000_0000 + 32'(v), v);
      end
      intr_req = 4'hF;
      tick(1);
      intr_req = '0;
      tick(10);
      check("t6_all_served", 64'(exp_q.size()), 64'd0);
      check("t6_pending_clr", 64'(pending), 64'd0);

      // Vector 0 re-requested right after its grant while 1..3 still wait.
`ifdef MSIX_RR_ARB_EN
      push_exp({32'h1, 32'h40},  32'hD000_0000, 0);
      push_exp({32'h1, 32'h140}, 32'hD000_0001, 1);
      push_exp({32'h1, 32'h240}, 32'hD000_0002, 2);
      push_exp({32'h1, 32'h340}, 32'hD000_0003, 3);
      push_exp({32'h1, 32'h40},  32'hD000_0000, 0);
`else
      push_exp({32'h1, 32'h40},  32'hD000_0000, 0);
      push_exp({32'h1, 32'h140}, 32'hD000_0001, 1);
      push_exp({32'h1, 32'h40},  32'hD000_0000, 0);
      push_exp({32'h1, 32'h240}, 32'hD000_0002, 2);
      push_exp({32'h1, 32'h340}, 32'hD000_0003, 3);
`endif
      intr_req = 4'hF;
      tick(1);
      intr_req = '0;
      tick(2);
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      tick(12);
      check("t7_order_done", 64'(exp_q.size()), 64'd0);
      check("t7_pending_clr", 64'(pending), 64'd0);

      // Reset during SEND drops the request and restores the table.
      wr_ready = 1'b0;
      intr_req = 4'b1100;
      tick(1);
      intr_req = '0;
      tick(1);
      check("t8_valid", 64'(wr_valid), 64'd1);
      check("t8_vec", 64'(wr_vec), 64'd2);
      rst = 1'b1;
      tick(1);
      check("t8_rst_valid", 64'(wr_valid), 64'd0);
      check("t8_rst_pending", 64'(pending), 64'd0);
      check("t8_rst_busy", 64'(busy), 64'd0);
      check("t8_rst_addr", wr_addr, 64'd0);
      rst = 1'b0;
      wr_ready = 1'b1;
      intr_req = 4'b0001;
      tick(1);
      intr_req = '0;
      tick(4);
      check("t8_mask_reset_no_valid", 64'(wr_valid), 64'd0);
      check("t8_mask_reset_pending", 64'(pending), 64'h1);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/msix_intr_gen.md
# msix_intr_gen

Device-side MSI-X interrupt generator. Holds a per-vector table of message address, data and mask. Latches interrupt events as pending bits and turns each unmasked pending vector into a single 32-bit memory-write request toward the host interface. The host-side model detects an interrupt by observing that DW write at the programmed address.

## Interface
- NUM_VEC, 4: number of MSI-X vectors, 1..32
- VEC_W, $clog2(NUM_VEC) (min 1): vector index width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- intr_req  in  NUM_VEC  one-cycle event pulse per vector
- msix_enable  in  1  MSI-X enable; 0 = no writes issued, events still latched
- func_mask  in  1  function mask; 1 = no writes issued, events still latched
- cfg_we  in  1  table write strobe
- cfg_vec  in  VEC_W  table entry index
- cfg_field  in  2  0 = addr_lo, 1 = addr_hi, 2 = data, 3 = ctrl (bit0 = vector mask)
- cfg_wdata  in  32  table write data
- wr_valid  out  1  write request valid
- wr_ready  in  1  host accepts write
- wr_addr  out  64  write address
- wr_data  out  32  write data (one DW)
- wr_vec  out  VEC_W  vector of current request
- pending  out  NUM_VEC  pending bit array (PBA)
- busy  out  1  request outstanding (state SEND)

## Operation
- Reset values: table addr/data = 0, vector masks = 1, pending = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, wr_vec = 0, busy = 0, state IDLE.
- intr_req[v] = 1 sets pending[v] on the next edge. Repeated events on a pending vector coalesce into one write.
- Eligible vector: pending[v] & !mask[v] & msix_enable & !func_mask.
- State machine:
  - IDLE: if any vector is eligible, the arbiter picks one. Latch its addr, data and index into wr_addr/wr_data/wr_vec. Go to SEND.
  - SEND: wr_valid = 1. On wr_valid & wr_ready, clear pending[wr_vec] and go to IDLE.
- Set/clear collision: intr_req[v] in the same cycle as the handshake clearing pending[v] leaves pending[v] = 1. Set wins, giving one further write.
- Once wr_valid is asserted, wr_addr, wr_data and wr_vec stay constant until the handshake. Table writes, mask changes, msix_enable = 0 or func_mask = 1 do not retract or alter the in-flight request.
- cfg writes take effect on the next edge. cfg_vec >= NUM_VEC is ignored.
- ctrl write changes only mask. Bits 31:1 are ignored and read as 0.
- Unmasking a pending vector makes it eligible in the next IDLE cycle.
- rst mid-SEND drops the request. wr_valid = 0 on the next edge, and pending and the table return to reset values.

## Timing
- intr_req at edge N → pending at N+1 → wr_valid at N+2 (minimum latency 2).
- Handshake at edge M → IDLE at M+1 → next wr_valid at M+2. Sustained rate is 1 write per 2 cycles with wr_ready held high.
- wr_ready is ignored while wr_valid = 0. wr_valid never depends combinationally on wr_ready.

## Configuration
- MSIX_RR_ARB_EN defined: round-robin arbitration. Search starts at (last granted index + 1) mod NUM_VEC. The pointer updates on each handshake and resets to 0.
- MSIX_RR_ARB_EN undefined: fixed priority, lowest eligible index wins.

## Structure
- Package msix_pkg:
  - typedef msix_entry_t: addr[63:0], data[31:0], mask
  - cfg_field encodings MSIX_F_ADDR_LO/HI/DATA/CTRL
  - state enum {IDLE, SEND}
- Sub-module msix_arb (NUM_VEC request vector → one-hot grant + index + any). Round-robin vs fixed priority is selected inside msix_arb by MSIX_RR_ARB_EN.

## Test plan
- Program vec 0: addr 0x0000_0000_0000_0001, data 0x1234_5678, mask 0. Enable, pulse intr_req[0], wr_ready = 1 → wr_valid at N+2 with wr_addr = 0x1, wr_data = 0x1234_5678. pending[0] clears after the handshake.
- Masked vec 1 (mask = 1), pulse intr_req[1] → no write, pending[1] = 1. Write ctrl = 0 → exactly one write from vec 1.
- Pulse vec 2 three times while func_mask = 1 → single write after func_mask = 0 (coalescing).
- wr_ready held 0 for 10 cycles while the table entry is rewritten → wr_addr/wr_data unchanged until the handshake.
- intr_req[0] coincident with the handshake of vec 0 → second write to vec 0 follows.
- All 4 vectors pending, ready high → grant order 0,1,2,3 in both arbitration modes. With MSIX_RR_ARB_EN, re-pulse vec 0 after its grant while 1–3 are pending → vec 0 is served last. Assert rst during SEND → wr_valid = 0 and pending = 0 next cycle.
